// File: rtl/enum_index_lookup_arbiter.sv
// Round-robin shared lookup of table[min(sel+OFFSET, DEPTH-1)] for NUM_REQ requesters,
// with a registered valid/ready response stage and a register-file table written via cfg.
module enum_index_lookup_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 4,
    parameter int SEL_W   = 2,
    parameter int DATA_W  = 32,
    parameter int OFFSET  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SEL_W-1:0]     req_sel,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         cfg_we,
    input  logic [SEL_W-1:0]             cfg_addr,
    input  logic [DATA_W-1:0]            cfg_wdata,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_W-1:0]            resp_data,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic                         resp_clamped
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam logic [SEL_W:0]  OFF_EXT = (SEL_W+1)'(OFFSET);
    localparam logic [SEL_W:0]  MAX_IDX = (SEL_W+1)'(DEPTH-1);

    logic [DATA_W-1:0] lut_q [DEPTH];
    logic [DATA_W-1:0] lut_d [DEPTH];
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic              resp_clamped_q, resp_clamped_d;

    logic              slot_free;
    logic              grant_found;
    logic              grant_ok;
    logic [ID_W-1:0]   grant_id;
    logic [SEL_W-1:0]  grant_sel;
    logic [SEL_W:0]    sum;
    logic [SEL_W-1:0]  idx;
    logic              clamped;

    // Circular successor: (base + k) mod NUM_REQ without relying on power-of-two NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred,
    // and combinational blocks use blocking '=' while clocked blocks use non-blocking '<='.
    always_comb begin
        slot_free   = !resp_valid_q || resp_ready;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[rr_index(ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_id    = rr_index(ptr_q, k);
            end
        end
        grant_ok  = grant_found && slot_free && rst_n;
        req_ready = '0;
        if (grant_ok) req_ready[grant_id] = 1'b1;
    end

    // Widened sum keeps the carry so large selectors saturate instead of wrapping.
    always_comb begin
        grant_sel = req_sel[grant_id*SEL_W +: SEL_W];
        sum       = {1'b0, grant_sel} + OFF_EXT;
        if (sum > MAX_IDX) begin
            idx     = SEL_W'(DEPTH-1);
            clamped = 1'b1;
        end else begin
            idx     = sum[SEL_W-1:0];
            clamped = 1'b0;
        end
    end

    always_comb begin
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_id_d      = resp_id_q;
        resp_clamped_d = resp_clamped_q;
        ptr_d          = ptr_q;
        if (grant_ok) begin
            // Reads lut_q, so a same-cycle cfg write to this entry is seen only next cycle.
            resp_valid_d   = 1'b1;
            resp_data_d    = lut_q[idx];
            resp_id_d      = grant_id;
            resp_clamped_d = clamped;
            ptr_d          = rr_index(grant_id, 1);
        end else if (resp_ready) begin
            resp_valid_d   = 1'b0;
        end
    end

    always_comb begin
        lut_d = lut_q;
        if (cfg_we) lut_d[cfg_addr] = cfg_wdata;
    end

    // NOTE: the table is a small register file that must read back zero after reset,
    // so every entry is reset here; a RAM-backed table would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
            ptr_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_id_q      <= '0;
            resp_clamped_q <= 1'b0;
        end else begin
            lut_q          <= lut_d;
            ptr_q          <= ptr_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_id_q      <= resp_id_d;
            resp_clamped_q <= resp_clamped_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_id      = resp_id_q;
    assign resp_clamped = resp_clamped_q;

endmodule

// File: tb/tb_enum_index_lookup_arbiter.sv
// Directed bench for enum_index_lookup_arbiter: vector table for single-requester clamping and
// round-robin, plus hand-written backpressure, collision, async reset and sparse sequences.
module tb_enum_index_lookup_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  req_sel;
    logic [3:0]  req_ready;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_id;
    logic        resp_clamped;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  sel;
        logic        rr;
        logic [3:0]  exp_rdy;
        logic        exp_v;
        logic [31:0] exp_d;
        logic [1:0]  exp_id;
        logic        exp_cl;
    } vec_t;

    vec_t vecs[$];

    enum_index_lookup_arbiter #(
        .NUM_REQ(4), .DEPTH(4), .SEL_W(2), .DATA_W(32), .OFFSET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_clamped(resp_clamped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] valid, input logic [7:0] sel, input logic rr,
                                 input logic [3:0] exp_rdy, input logic exp_v,
                                 input logic [31:0] exp_d, input logic [1:0] exp_id,
                                 input logic exp_cl);
        vec_t v;
        v.valid = valid; v.sel = sel; v.rr = rr; v.exp_rdy = exp_rdy;
        v.exp_v = exp_v; v.exp_d = exp_d; v.exp_id = exp_id; v.exp_cl = exp_cl;
        return v;
    endfunction

    // Called just after a rising edge: drive, check grant mid-cycle, clock, check response.
    task automatic apply_vec(input vec_t v, input string tag);
        req_valid  = v.valid;
        req_sel    = v.sel;
        resp_ready = v.rr;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_rdy));
        @(posedge clk); #1;
        check({tag, " resp_valid"}, 32'(resp_valid), 32'(v.exp_v));
        if (v.exp_v) begin
            check({tag, " resp_data"}, resp_data, v.exp_d);
            check({tag, " resp_id"}, 32'(resp_id), 32'(v.exp_id));
            check({tag, " resp_clamped"}, 32'(resp_clamped), 32'(v.exp_cl));
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic load_table();
        req_valid = '0;
        for (int a = 0; a < 4; a++) cfg_write(2'(a), 32'hA0 + 32'(a));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 4'hF; req_sel = '0; resp_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        // Single requester 0, sel 0..3 (idx 1,2,3, then clamped 3), then an idle cycle.
        vecs.push_back(mkv(4'b0001, 8'h00, 1'b1, 4'b0001, 1'b1, 32'hA1, 2'd0, 1'b0));
        vecs.push_back(mkv(4'b0001, 8'h01, 1'b1, 4'b0001, 1'b1, 32'hA2, 2'd0, 1'b0));
        vecs.push_back(mkv(4'b0001, 8'h02, 1'b1, 4'b0001, 1'b1, 32'hA3, 2'd0, 1'b0));
        vecs.push_back(mkv(4'b0001, 8'h03, 1'b1, 4'b0001, 1'b1, 32'hA3, 2'd0, 1'b1));
        vecs.push_back(mkv(4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h0,  2'd0, 1'b0));
        // All valid with sel=i; pointer sits at 1 after the last grant to requester 0.
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b0010, 1'b1, 32'hA2, 2'd1, 1'b0));
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b0100, 1'b1, 32'hA3, 2'd2, 1'b0));
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3, 1'b1));
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b0001, 1'b1, 32'hA1, 2'd0, 1'b0));
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b0010, 1'b1, 32'hA2, 2'd1, 1'b0));
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b0100, 1'b1, 32'hA3, 2'd2, 1'b0));
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3, 1'b1));
        vecs.push_back(mkv(4'b1111, 8'hE4, 1'b1, 4'b0001, 1'b1, 32'hA1, 2'd0, 1'b0));
        vecs.push_back(mkv(4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h0,  2'd0, 1'b0));

        // Reset state, with requests pending to show req_ready is held low.
        #3;
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset resp_id", 32'(resp_id), 32'd0);
        check("reset resp_clamped", 32'(resp_clamped), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        load_table();

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: pointer at 1, accept requester 1, then stall 5 cycles.
        apply_vec(mkv(4'hF, 8'hE4, 1'b1, 4'b0010, 1'b1, 32'hA2, 2'd1, 1'b0), "bp accept");
        for (int c = 0; c < 5; c++)
            apply_vec(mkv(4'hF, 8'hE4, 1'b0, 4'b0000, 1'b1, 32'hA2, 2'd1, 1'b0),
                      $sformatf("bp hold%0d", c));
        apply_vec(mkv(4'hF, 8'hE4, 1'b1, 4'b0100, 1'b1, 32'hA3, 2'd2, 1'b0), "bp release");
        apply_vec(mkv(4'h0, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0), "bp drain");

        // Collision: requester 3 sel=1 reads idx 2 while idx 2 is written.
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h55;
        apply_vec(mkv(4'b1000, 8'h40, 1'b1, 4'b1000, 1'b1, 32'hA2, 2'd3, 1'b0), "coll same");
        cfg_we = 1'b0;
        apply_vec(mkv(4'b1000, 8'h40, 1'b1, 4'b1000, 1'b1, 32'h55, 2'd3, 1'b0), "coll next");
        apply_vec(mkv(4'h0, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0), "coll idle");

        // Async reset while holding a response from requester 2.
        apply_vec(mkv(4'b0100, 8'h00, 1'b1, 4'b0100, 1'b1, 32'hA1, 2'd2, 1'b0), "rst load");
        resp_ready = 1'b0; req_valid = 4'b1010;
        #1;
        check("rst pre hold req_ready", 32'(req_ready), 32'd0);
        check("rst pre resp_valid", 32'(resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst async resp_valid", 32'(resp_valid), 32'd0);
        check("rst async resp_data", resp_data, 32'd0);
        check("rst async resp_id", 32'(resp_id), 32'd0);
        check("rst async req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        apply_vec(mkv(4'b1010, 8'h00, 1'b1, 4'b0010, 1'b1, 32'h0, 2'd1, 1'b0), "rst first");
        apply_vec(mkv(4'b1010, 8'h00, 1'b1, 4'b1000, 1'b1, 32'h0, 2'd3, 1'b0), "rst second");
        apply_vec(mkv(4'h0, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0), "rst idle");
        load_table();

        // Sparse: requester 3 alone (sel=2), idle gap, then 0 and 3 with pointer wrapped to 0.
        apply_vec(mkv(4'b1000, 8'h80, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3, 1'b0), "sparse r3");
        for (int c = 0; c < 3; c++)
            apply_vec(mkv(4'h0, 8'h80, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0),
                      $sformatf("sparse idle%0d", c));
        apply_vec(mkv(4'b1001, 8'h80, 1'b1, 4'b0001, 1'b1, 32'hA1, 2'd0, 1'b0), "sparse r0");
        apply_vec(mkv(4'b1001, 8'h80, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3, 1'b0), "sparse r3b");
        apply_vec(mkv(4'h0, 8'h00, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0), "sparse end");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
